rtc_core: RTL

// - Parametrised time-of-day core: replaces the fixed divider + counter + edit trio with one block.
// - Provides a tick divider, an H:M:S counter, a button-driven edit FSM, 12/24 h display mode and BCD output.
// - Sits between the debounce instances and the display driver; the display driver consumes bcd_o.

---
 rtl/rtc_core.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rtc_core.sv
// rtc_core: time-of-day core with tick divider, H:M:S counter, button-driven
// edit FSM, 12/24 h display selection and BCD output.
// Optional alarm comparator is built only when RTC_ALARM_EN is defined;
// otherwise alarm_o is tied low and the alarm inputs are ignored.
module rtc_core #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int TICK_HZ      = 1,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic        clock,
  input  logic        reset_i,
  input  logic        btn_config_i,
  input  logic        btn_inc_i,
  input  logic        btn_dec_i,
  input  logic        mode_12h_i,
  input  logic [4:0]  alarm_h_i,
  input  logic [5:0]  alarm_m_i,
  input  logic        alarm_arm_i,
  output logic [5:0]  sec_o,
  output logic [5:0]  min_o,
  output logic [4:0]  hour_o,
  output logic        pm_o,
  output logic [23:0] bcd_o,
  output logic        tick_o,
  output logic [1:0]  edit_o,
  output logic        blink_o,
  output logic        alarm_o
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int BW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_CYCLES - 1);

  // Encoding doubles as the edit_o field code.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    EDIT_S = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          cfg_q, inc_q, dec_q;
  logic          cfg_rise, inc_rise, dec_rise;
  logic          cfg_act, inc_act, dec_act;
  logic          swallow;
  logic          tick;
  logic [4:0]    hour_disp;

  // Previous button levels for rise detection.
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      cfg_q <= 1'b0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      cfg_q <= btn_config_i;
      inc_q <= btn_inc_i;
      dec_q <= btn_dec_i;
    end
  end

  assign cfg_rise = btn_config_i & ~cfg_q;
  assign inc_rise = btn_inc_i & ~inc_q;
  assign dec_rise = btn_dec_i & ~dec_q;

  // cfg beats inc/dec; simultaneous inc+dec cancel; a rise that silences the
  // alarm is consumed entirely.
  assign cfg_act = cfg_rise & ~swallow;
  assign inc_act = inc_rise & ~dec_rise & ~cfg_rise & ~swallow;
  assign dec_act = dec_rise & ~inc_rise & ~cfg_rise & ~swallow;

  assign tick = (state_q == RUN) && (div_q == DIV_MAX);

  // Divider runs only in RUN, so leaving EDIT_S restarts a full second.
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i)              div_q <= '0;
    else if (state_q != RUN)   div_q <= '0;
    else if (tick)             div_q <= '0;
    else                       div_q <= div_q + 1'b1;
  end

  // Next-state and next-counter logic: cascade in RUN, single-field edit otherwise.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    if (cfg_act) state_d = state_t'(state_q + 2'd1);
    case (state_q)
      RUN: begin
        if (tick) begin
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d  = 6'd0;
              hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
      EDIT_H: begin
        if (inc_act)      hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        else if (dec_act) hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
      end
      EDIT_M: begin
        if (inc_act)      min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        else if (dec_act) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
      end
      EDIT_S: begin
        if (inc_act)      sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        else if (dec_act) sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
      end
    endcase
  end

  // State and time registers.
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= RUN;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
    end
  end

  // Blink phase restarts visible on every state change, then toggles per period.
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (state_d != state_q) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else if (state_q != RUN) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic alarm_q;

  assign swallow = alarm_q & (cfg_rise | inc_rise | dec_rise);

  // Ring when a counted second lands on HH:MM:00; tick implies RUN so edits never fire it.
  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i)
      alarm_q <= 1'b0;
    else if (!alarm_arm_i || swallow)
      alarm_q <= 1'b0;
    else if (tick && hour_d == alarm_h_i && min_d == alarm_m_i && sec_d == 6'd0)
      alarm_q <= 1'b1;
  end

  assign alarm_o = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_h_i, alarm_m_i, alarm_arm_i};
  assign swallow      = 1'b0;
  assign alarm_o      = 1'b0;
`endif

  // Binary 0-59 to two BCD digits.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] tens;
    r    = v;
    tens = 4'd0;
    for (int k = 0; k < 5; k++) begin
      if (r >= 6'd10) begin
        r    = r - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(r)};
  endfunction

  // Display hour: 0 shows as 12 and 13-23 fold down in 12 h mode.
  always_comb begin
    hour_disp = hour_q;
    if (mode_12h_i) begin
      if (hour_q == 5'd0)      hour_disp = 5'd12;
      else if (hour_q > 5'd12) hour_disp = hour_q - 5'd12;
    end
  end

  assign bcd_o   = {to_bcd({1'b0, hour_disp}), to_bcd(min_q), to_bcd(sec_q)};
  assign sec_o   = sec_q;
  assign min_o   = min_q;
  assign hour_o  = hour_q;
  assign pm_o    = (hour_q >= 5'd12);
  assign tick_o  = tick;
  assign edit_o  = state_q;
  assign blink_o = blink_q & (state_q != RUN);

endmodule
